// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler.
// Optional build macro: FFT_SCHED_REORDER_EN (natural-order unload).
package fft_sched_pkg;

    localparam int N_PTS  = 2048;
    localparam int BANK_W = 2;
    localparam int ADDR_W = 9;
    localparam int IDX_W  = BANK_W + ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_RUN       = 3'd4,
        ST_UNLOAD    = 3'd5
    } sched_state_t;

    // Bank-port owner encodings
    localparam logic [1:0] MUX_LOAD = 2'd0;
    localparam logic [1:0] MUX_FFT  = 2'd1;
    localparam logic [1:0] MUX_UNL  = 2'd2;
    localparam logic [1:0] MUX_NONE = 2'd3;

    // Radix-4 digit reversal with the odd radix-2 digit on top:
    // j = {d5, d4, d3, d2, d1, d0} -> p = {d0, d1, d2, d3, d4, d5}
    function automatic logic [IDX_W-1:0] digit_rev(input logic [IDX_W-1:0] j);
        return {j[1:0], j[3:2], j[5:4], j[7:6], j[9:8], j[10]};
    endfunction

    // Port owner implied by a scheduler state
    function automatic logic [1:0] mux_of(input sched_state_t s);
        case (s)
            ST_IDLE, ST_LOAD:                 return MUX_LOAD;
            ST_START, ST_WAIT_BUSY, ST_RUN:   return MUX_FFT;
            ST_UNLOAD:                        return MUX_UNL;
            default:                          return MUX_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fft_unload_gen.sv
// Unload address generator: walks j = 0..2047, issues RAM reads and
// tracks the one-cycle-latency valid/last pipeline toward the consumer.
// Handshake: a beat transfers on a cycle where oOUT_VALID & iOUT_READY;
// once valid is raised, the word, valid and last hold until that cycle.
// Optional build macro: FFT_SCHED_REORDER_EN (digit-reversed addressing).
module fft_unload_gen
    import fft_sched_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iEN,
    input  logic              iOUT_READY,
    output logic              oRD_EN,
    output logic [BANK_W-1:0] oBANK,
    output logic [ADDR_W-1:0] oADDR,
    output logic              oOUT_VALID,
    output logic              oOUT_LAST
);

    // Extra top bit marks that all 2048 reads have been issued
    logic [IDX_W:0]   j_q;
    logic [IDX_W-1:0] p;

    // A read may be issued when the output register is empty or draining
    assign oRD_EN = iEN & ~j_q[IDX_W] & (~oOUT_VALID | iOUT_READY);

`ifdef FFT_SCHED_REORDER_EN
    assign p = digit_rev(j_q[IDX_W-1:0]);
`else
    assign p = j_q[IDX_W-1:0];
`endif

    assign oBANK = p[IDX_W-1:ADDR_W];
    assign oADDR = p[ADDR_W-1:0];

    // Read index: cleared outside UNLOAD, advances on every issued read
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            j_q <= '0;
        end else if (!iEN) begin
            j_q <= '0;
        end else if (oRD_EN) begin
            j_q <= j_q + 1'b1;
        end
    end

    // Valid/last follow the read by one cycle and hold under backpressure
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oOUT_VALID <= 1'b0;
            oOUT_LAST  <= 1'b0;
        end else begin
            oOUT_VALID <= oRD_EN | (oOUT_VALID & ~iOUT_READY);
            if (oRD_EN) begin
                oOUT_LAST <= (j_q[IDX_W-1:0] == IDX_W'(N_PTS - 1));
            end else if (iOUT_READY) begin
                oOUT_LAST <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the 2048-point FFT: load, start, wait, unload,
// with exclusive ownership of the four RAM banks.
// Optional build macro: FFT_SCHED_REORDER_EN (natural-order unload).
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter bit RES_SET = 1'b0
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iIN_VALID,
    output logic       oIN_READY,
    output logic       oLOAD_WE,
    output logic [1:0] oLOAD_BANK,
    output logic [8:0] oLOAD_ADDR,
    output logic       oFFT_START,
    input  logic       iFFT_RDY,
    output logic       oUNL_RD_EN,
    output logic [1:0] oUNL_BANK,
    output logic [8:0] oUNL_ADDR,
    output logic       oOUT_VALID,
    input  logic       iOUT_READY,
    output logic       oOUT_LAST,
    output logic [1:0] oMUX_SEL,
    output logic       oRES_SET,
    output logic       oBUSY,
    output logic       oERR
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] n_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       mux_q;
    logic             err_q, err_d;
    logic             tc;
    logic             out_valid, out_last;

    assign oIN_READY  = (state_q == ST_LOAD);
    assign oLOAD_WE   = iIN_VALID & oIN_READY;
    assign oLOAD_BANK = n_q[IDX_W-1:ADDR_W];
    assign oLOAD_ADDR = n_q[ADDR_W-1:0];
    assign oFFT_START = (state_q == ST_START);
    assign oBUSY      = (state_q != ST_IDLE);
    assign oMUX_SEL   = mux_q;
    assign oERR       = err_q;
    assign oRES_SET   = RES_SET;
    assign oOUT_VALID = out_valid;
    assign oOUT_LAST  = out_last;
    assign tc         = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state logic; in RUN a completing engine beats the timeout
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE:      if (iIN_VALID) state_d = ST_LOAD;
            ST_LOAD:      if (oLOAD_WE && n_q == IDX_W'(N_PTS - 1)) state_d = ST_START;
            ST_START:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tc) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (!iFFT_RDY) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iFFT_RDY) begin
                    state_d = ST_UNLOAD;
                end else if (tc) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_UNLOAD:    if (out_valid && iOUT_READY && out_last) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State register, error pulse and registered port owner
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            mux_q   <= MUX_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_d != state_q) mux_q <= mux_of(state_d);
        end
    end

    // Sample counter; wraps to 0 after the 2048th accepted sample
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            n_q <= '0;
        end else if (state_q == ST_IDLE) begin
            n_q <= '0;
        end else if (oLOAD_WE) begin
            n_q <= n_q + 1'b1;
        end
    end

    // Cycles since START, covering WAIT_BUSY and RUN
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cnt_q <= '0;
        end else if (state_q == ST_START || state_q == ST_WAIT_BUSY || state_q == ST_RUN) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    fft_unload_gen u_unload (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iEN        (state_q == ST_UNLOAD),
        .iOUT_READY (iOUT_READY),
        .oRD_EN     (oUNL_RD_EN),
        .oBANK      (oUNL_BANK),
        .oADDR      (oUNL_ADDR),
        .oOUT_VALID (out_valid),
        .oOUT_LAST  (out_last)
    );

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: RAM and FFT-engine models, random sample and
// consumer stimulus, scoreboard of expected unload words.
`timescale 1ns/1ps
module tb_fft_frame_sched;

    localparam int NP  = 2048;
    localparam int TMO = 4096;

    logic       iCLK = 1'b0;
    logic       iRESET;
    logic       iIN_VALID;
    logic       oIN_READY, oLOAD_WE;
    logic [1:0] oLOAD_BANK;
    logic [8:0] oLOAD_ADDR;
    logic       oFFT_START;
    logic       iFFT_RDY;
    logic       oUNL_RD_EN;
    logic [1:0] oUNL_BANK;
    logic [8:0] oUNL_ADDR;
    logic       oOUT_VALID, iOUT_READY, oOUT_LAST;
    logic [1:0] oMUX_SEL;
    logic       oRES_SET, oBUSY, oERR;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] samples [NP];
    logic [15:0] ram [NP];
    logic [15:0] ram_q;
    logic [15:0] in_data;
    logic [15:0] exp_q [$];
    int          fft_rise;
    int          err_seen = 0;
    int          start_seen = 0;

    fft_frame_sched #(.TIMEOUT(TMO), .RES_SET(1'b0)) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iIN_VALID  (iIN_VALID),
        .oIN_READY  (oIN_READY),
        .oLOAD_WE   (oLOAD_WE),
        .oLOAD_BANK (oLOAD_BANK),
        .oLOAD_ADDR (oLOAD_ADDR),
        .oFFT_START (oFFT_START),
        .iFFT_RDY   (iFFT_RDY),
        .oUNL_RD_EN (oUNL_RD_EN),
        .oUNL_BANK  (oUNL_BANK),
        .oUNL_ADDR  (oUNL_ADDR),
        .oOUT_VALID (oOUT_VALID),
        .iOUT_READY (iOUT_READY),
        .oOUT_LAST  (oOUT_LAST),
        .oMUX_SEL   (oMUX_SEL),
        .oRES_SET   (oRES_SET),
        .oBUSY      (oBUSY),
        .oERR       (oERR)
    );

    // ---------------- clock / reset ----------------
    always #5 iCLK = ~iCLK;

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", oIN_READY, 0);
        check("rst_load_we", oLOAD_WE, 0);
        check("rst_load_idx", {oLOAD_BANK, oLOAD_ADDR}, 0);
        check("rst_start", oFFT_START, 0);
        check("rst_rd_en", oUNL_RD_EN, 0);
        check("rst_unl_idx", {oUNL_BANK, oUNL_ADDR}, 0);
        check("rst_valid", oOUT_VALID, 0);
        check("rst_last", oOUT_LAST, 0);
        check("rst_mux", oMUX_SEL, 3);
        check("rst_res_set", oRES_SET, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_err", oERR, 0);
    endtask

    // Physical location of the k-th unloaded word (sample n sits at index n)
    function automatic int phys_of(input int k);
`ifdef FFT_SCHED_REORDER_EN
        return (k % 4) * 512 + ((k / 4) % 4) * 128 + ((k / 16) % 4) * 32 +
               ((k / 64) % 4) * 8 + ((k / 256) % 4) * 2 + (k / 1024);
`else
        return k;
`endif
    endfunction

    // ---------------- models ----------------
    // Banked RAM with one-cycle read latency; q holds without a read
    always @(posedge iCLK) begin
        if (oLOAD_WE) ram[{oLOAD_BANK, oLOAD_ADDR}] <= in_data;
        if (oUNL_RD_EN) ram_q <= ram[{oUNL_BANK, oUNL_ADDR}];
    end

    // FFT engine: busy one cycle after start, idle again fft_rise cycles later
    initial begin
        iFFT_RDY = 1'b1;
        forever begin
            @(negedge iCLK);
            if (oFFT_START) begin
                @(posedge iCLK);
                #1 iFFT_RDY = 1'b0;
                if (fft_rise < 0) repeat (4200) @(posedge iCLK);
                else repeat (fft_rise) @(posedge iCLK);
                #1 iFFT_RDY = 1'b1;
            end
        end
    end

    always @(negedge iCLK) begin
        if (oERR) err_seen++;
        if (oFFT_START) start_seen++;
    end

    // ---------------- driver / scoreboard ----------------
    task automatic run_frame(input int valid_pct, input int rdy_pct, input int rise,
                             input int abort_at);
        int acc = 0, guard = 0, lat = 0, beats = 0, reads = 0;
        int e0, s0, exp_err;
        bit aborted = 0, got_err = 0, got_unl = 0, done = 0, stalled = 0;
        logic [15:0] h_data, e;
        logic [10:0] h_addr;
        logic        h_last;

        fft_rise = rise;
        e0 = err_seen;
        s0 = start_seen;
        exp_err = (rise < 0) ? 1 : 0;
        for (int i = 0; i < NP; i++) samples[i] = 16'($urandom_range(16'hFFFF));
        exp_q.delete();
        for (int k = 0; k < NP; k++) exp_q.push_back(samples[phys_of(k)]);

        // load phase
        while (acc < NP && guard < 20000 && !aborted) begin
            @(posedge iCLK);
            #1;
            iIN_VALID = ($urandom_range(99) < valid_pct);
            in_data = samples[acc];
            if (acc == abort_at) begin
                iIN_VALID = 1'b1;
                #2 iRESET = 1'b0;
                #1 check_reset_outputs();
                aborted = 1;
            end else begin
                @(negedge iCLK);
                if (oLOAD_WE) begin
                    check("ld_bank", oLOAD_BANK, acc / 512);
                    check("ld_addr", oLOAD_ADDR, acc % 512);
                    if (acc == 0 || acc == 1024) check("ld_mux", oMUX_SEL, 0);
                    acc++;
                end
            end
            guard++;
        end
        if (aborted) begin
            @(posedge iCLK);
            #1;
            iIN_VALID = 1'b0;
            iRESET = 1'b1;
            @(negedge iCLK);
            check("post_abort_mux", oMUX_SEL, 3);
            check("post_abort_busy", oBUSY, 0);
            return;
        end
        check("load_done", acc, NP);
        @(posedge iCLK);
        #1 iIN_VALID = 1'b0;
        @(negedge iCLK);
        check("start_after_last", oFFT_START, 1);

        // run phase; input valid is driven to show it is ignored
        iIN_VALID = 1'b1;
        while (!got_err && !got_unl && lat < 6000) begin
            @(negedge iCLK);
            lat++;
            if (lat == 1) check("wb_mux", oMUX_SEL, 1);
            if (lat == 5) begin
                check("run_in_ready", oIN_READY, 0);
                check("run_load_we", oLOAD_WE, 0);
                check("run_busy", oBUSY, 1);
            end
            if (oERR) got_err = 1;
            else if (oMUX_SEL == 2'd2) got_unl = 1;
        end
        iIN_VALID = 1'b0;
        check("run_end", got_err | got_unl, 1);

        if (rise < 0) begin
            check("err_lat", lat, TMO);
            check("err_busy", oBUSY, 0);
            check("err_mux", oMUX_SEL, 0);
            @(negedge iCLK);
            check("err_one_cycle", oERR, 0);
            check("err_idle", oBUSY, 0);
        end else begin
            check("unl_lat", lat, rise + 2);
            check("unl_err", oERR, 0);
            check("rd_en_first", oUNL_RD_EN, 1);
            check("rd_p", {oUNL_BANK, oUNL_ADDR}, phys_of(0));
            reads = 1;
            guard = 0;
            while (!done && guard < 20000) begin
                @(posedge iCLK);
                #1 iOUT_READY = ($urandom_range(99) < rdy_pct);
                @(negedge iCLK);
                guard++;
                if (stalled) begin
                    check("stall_valid", oOUT_VALID, 1);
                    check("stall_data", ram_q, h_data);
                    check("stall_last", oOUT_LAST, h_last);
                    check("stall_addr", {oUNL_BANK, oUNL_ADDR}, h_addr);
                end
                if (oUNL_RD_EN) begin
                    check("rd_p", {oUNL_BANK, oUNL_ADDR}, phys_of(reads % NP));
                    reads++;
                end
                if (oOUT_VALID && iOUT_READY) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = 16'hxxxx;
                    check("beat_data", ram_q, e);
                    beats++;
                    check("beat_last", oOUT_LAST, beats == NP);
                    if (oOUT_LAST) done = 1;
                end
                stalled = oOUT_VALID && !iOUT_READY;
                h_data = ram_q;
                h_last = oOUT_LAST;
                h_addr = {oUNL_BANK, oUNL_ADDR};
            end
            check("unl_beats", beats, NP);
            check("unl_reads", reads, NP);
            check("exp_q_empty", exp_q.size(), 0);
            @(posedge iCLK);
            #1 iOUT_READY = 1'b0;
            @(negedge iCLK);
            check("idle_busy", oBUSY, 0);
            check("idle_mux", oMUX_SEL, 0);
            check("idle_valid", oOUT_VALID, 0);
        end
        @(posedge iCLK);
        #1;
        check("err_count", err_seen - e0, exp_err);
        check("start_count", start_seen - s0, 1);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        iRESET = 1'b0;
        iIN_VALID = 1'b0;
        iOUT_READY = 1'b0;
        in_data = '0;
        fft_rise = 3100;
        repeat (3) @(posedge iCLK);
        #1 check_reset_outputs();
        iRESET = 1'b1;
        repeat (3) @(negedge iCLK);
        check("idle_mux_none", oMUX_SEL, 3);
        check("idle_busy0", oBUSY, 0);

        run_frame(100, 100, 3100, -1);
        run_frame(70, 50, $urandom_range(200, 20), -1);
        run_frame(100, 100, -1, -1);
        run_frame(90, 50, $urandom_range(200, 20), -1);
        run_frame(100, 100, 100, 1000);
        run_frame(100, 60, $urandom_range(200, 20), -1);
        run_frame(100, 50, TMO - 2, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
Frame-level scheduler for the 2048-point radix-4/radix-2 FFT core. It owns the four 512-word RAM banks between frames. It loads 2048 input samples into the banks, pulses start into the FFT address/control engine, and waits for that engine's ready. It then unloads 2048 results to a downstream consumer over a valid/ready handshake, while driving the RAM-port mux so only one agent (loader, FFT engine, unloader) touches the banks at a time.

Parameters:
TIMEOUT, 4096, max cycles in RUN before the frame is declared failed
RES_SET, 0, RAM set holding final results (0 = set A, 1 = set B); drives oRES_SET

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous active-low reset
iIN_VALID  in  1  input sample valid (sample data itself goes straight to RAM)
oIN_READY  out  1  scheduler accepts a sample this cycle
oLOAD_WE  out  1  RAM write enable for the loader
oLOAD_BANK  out  2  loader bank select
oLOAD_ADDR  out  9  loader word address
oFFT_START  out  1  one-cycle start pulse to the FFT control engine
iFFT_RDY  in  1  ready/idle from the FFT control engine (high when idle)
oUNL_RD_EN  out  1  unloader RAM read enable (RAM read latency is exactly 1)
oUNL_BANK  out  2  unloader bank select
oUNL_ADDR  out  9  unloader word address
oOUT_VALID  out  1  result word on RAM q is valid
iOUT_READY  in  1  consumer accepts the result
oOUT_LAST  out  1  qualifies the 2048th result
oMUX_SEL  out  2  bank-port owner: 0 loader, 1 FFT engine, 2 unloader, 3 none
oRES_SET  out  1  = RES_SET, selects the result RAM set for unload reads
oBUSY  out  1  high in any state other than IDLE
oERR  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: all outputs 0, except oMUX_SEL = 3 and oRES_SET = RES_SET. State = IDLE, counters 0.
- States and transitions:
  - IDLE: go to LOAD when iIN_VALID = 1.
  - LOAD: go to START when the 2048th sample is accepted.
  - START: one cycle; oFFT_START = 1; go to WAIT_BUSY.
  - WAIT_BUSY: go to RUN when iFFT_RDY = 0.
  - RUN: go to UNLOAD when iFFT_RDY = 1. Go to IDLE with an oERR pulse when the run counter reaches TIMEOUT-1.
  - UNLOAD: go to IDLE when the last word is accepted (oOUT_VALID & iOUT_READY & oOUT_LAST).
- WAIT_BUSY is also covered by the timeout counter. The counter counts cycles since START.
- LOAD:
  - oIN_READY = 1 only in LOAD; oLOAD_WE = iIN_VALID & oIN_READY, combinational.
  - An 11-bit sample counter n advances on each accepted sample; oLOAD_BANK = n[10:9], oLOAD_ADDR = n[8:0].
  - Sample n lands at bank n/512, word n%512.
- UNLOAD:
  - 11-bit counter j; oUNL_RD_EN = UNLOAD & j_not_exhausted & (~oOUT_VALID | iOUT_READY).
  - j increments on every read.
  - oOUT_VALID (registered) <= oUNL_RD_EN | (oOUT_VALID & ~iOUT_READY). The RAM holds q while read enable is low.
  - oOUT_LAST is registered alongside oOUT_VALID for the read issued at j = 2047. It is held until accepted.
  - Physical index p = j (raw order); oUNL_BANK = p[10:9], oUNL_ADDR = p[8:0].
- oMUX_SEL: 0 in IDLE and LOAD, 1 in START/WAIT_BUSY/RUN, 2 in UNLOAD, 3 after reset until the first frame begins. It is registered, changing on the state-transition edge.
- Boundaries:
  - Backpressure with iOUT_READY = 0 holds the address, valid, and last.
  - iFFT_RDY rising in the same cycle as the timeout terminal count: completion wins, with no oERR.
  - iIN_VALID in non-LOAD states is ignored (oIN_READY = 0).
  - Reset mid-frame aborts immediately to IDLE with reset values.
  - Consecutive frames: IDLE lasts at least one cycle between frames.

Optional Feature:
FFT_SCHED_REORDER_EN.
- Defined: unload in natural frequency order. Split j into digits {d5 (bit 10), d4, d3, d2, d1, d0 (2 bits each)}; p = {d0, d1, d2, d3, d4, d5} (11 bits). Bank and address are derived from p as above.
- Undefined: p = j (core-native digit-reversed order).
- The handshake is identical in both builds.

Decomposition:
- Package fft_sched_pkg:
  - State encoding enum.
  - Constants N_PTS = 2048, BANK_W = 2, ADDR_W = 9.
  - MUX_* encodings.
  - Digit-reversal function.
- One sub-module, fft_unload_gen: j counter, optional reordering, read-enable/valid/last pipeline.
- LOAD, the FSM, and the timeout counter stay in the top level.

Test Plan:
- Full frame, iIN_VALID held high:
  - Samples 0, 511, 512, 2047 map to (bank, addr) (0,0), (0,511), (1,0), (3,511).
  - oFFT_START pulses once, on the cycle after sample 2047.
  - A model FFT with rdy dropping 1 cycle after start and rising 3100 cycles later yields UNLOAD and 2048 valid beats, with oOUT_LAST on beat 2048 only.
- Random iOUT_READY (50%): no beat lost or duplicated; address and data are stable while stalled; exactly 2048 reads.
- FFT_SCHED_REORDER_EN defined: j = 1 gives p = 512 (bank 1, addr 0); j = 1024 gives p = 1 (bank 0, addr 1); j = 2047 gives p = 2047.
- Model holds rdy low forever: oERR pulses at 4096 cycles after start, then IDLE with oBUSY = 0; the next frame completes normally.
- iRESET asserted at input sample 1000: all outputs return to reset values asynchronously; a new frame restarts at bank 0, addr 0.
- rdy rising on the exact timeout terminal cycle: UNLOAD is entered and oERR stays 0.
